// File: rtl/packet_crc_framer.sv
// packet_crc_framer
// Transmit-side framer. Takes a serial payload under valid/ready, runs an
// 8-bit LFSR CRC over the payload bits of each frame and appends the 8 CRC
// bits (MSB first) so every frame is exactly PKT_BITS bits long. The output
// is a single registered, back-pressurable serial stage.
//
// Ports:
//   clk        clock, all logic on rising edge
//   rst        asynchronous active-high reset
//   bit_in     payload bit
//   valid_in   bit_in valid
//   ready_out  framer accepts bit_in this cycle (combinational)
//   bit_out    framed output bit (registered)
//   valid_out  bit_out valid (registered)
//   ready_in   downstream accepts bit_out
//   sop        bit_out is frame bit 0 (qualified by valid_out)
//   eop        bit_out is the last CRC bit (qualified by valid_out)
module packet_crc_framer #(
  parameter int PKT_BITS = 1504,
  parameter int CRC_SIZE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_in,
  input  logic valid_in,
  output logic ready_out,
  output logic bit_out,
  output logic valid_out,
  input  logic ready_in,
  output logic sop,
  output logic eop
);

  localparam int PAY_BITS = PKT_BITS - CRC_SIZE;
  localparam int CW       = $clog2(PKT_BITS);
  localparam logic [CW-1:0] LAST_PAY = CW'(PAY_BITS - 1);
  localparam logic [CW-1:0] LAST_CRC = CW'(CRC_SIZE - 1);
  // Bits 6..0 of the next CRC take crc[i+1], XORed with feedback where set.
  localparam logic [6:0] TAPS = 7'b010_1011;

  typedef enum logic {PAYLOAD, CRC} state_t;

  state_t        state, state_next;
  logic [CW-1:0] count, count_next;
  logic [7:0]    crc, crc_next, crc_upd;
  logic [7:0]    crc_sh, crc_sh_next;
  logic          bit_out_next, valid_out_next, sop_next, eop_next;
  logic          slot_free, take, fb;

  assign slot_free = !valid_out || ready_in;
  assign ready_out = (state == PAYLOAD) && slot_free;
  assign take      = valid_in && ready_out;

  // CRC after absorbing bit_in
  assign fb         = crc[0] ^ bit_in;
  assign crc_upd[7] = fb;
  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_crc
      assign crc_upd[gi] = crc[gi+1] ^ (TAPS[gi] & fb);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= PAYLOAD;
      count     <= '0;
      crc       <= '0;
      crc_sh    <= '0;
      bit_out   <= 1'b0;
      valid_out <= 1'b0;
      sop       <= 1'b0;
      eop       <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      crc       <= crc_next;
      crc_sh    <= crc_sh_next;
      bit_out   <= bit_out_next;
      valid_out <= valid_out_next;
      sop       <= sop_next;
      eop       <= eop_next;
    end
  end

  always_comb begin
    // Hold everything unless the output slot is free.
    state_next     = state;
    count_next     = count;
    crc_next       = crc;
    crc_sh_next    = crc_sh;
    bit_out_next   = bit_out;
    valid_out_next = valid_out;
    sop_next       = sop;
    eop_next       = eop;

    case (state)
      PAYLOAD: begin
        if (take) begin
          bit_out_next   = bit_in;
          valid_out_next = 1'b1;
          sop_next       = (count == '0);
          eop_next       = 1'b0;
          if (count == LAST_PAY) begin
            // Freeze the finished CRC for shifting out and reseed for the
            // next frame.
            crc_sh_next = crc_upd;
            crc_next    = '0;
            count_next  = '0;
            state_next  = CRC;
          end else begin
            crc_next   = crc_upd;
            count_next = count + 1'b1;
          end
        end else if (slot_free) begin
          valid_out_next = 1'b0;
          sop_next       = 1'b0;
          eop_next       = 1'b0;
        end
      end
      CRC: begin
        if (slot_free) begin
          bit_out_next   = crc_sh[7];
          crc_sh_next    = {crc_sh[6:0], 1'b0};
          valid_out_next = 1'b1;
          sop_next       = 1'b0;
          eop_next       = (count == LAST_CRC);
          if (count == LAST_CRC) begin
            count_next = '0;
            state_next = PAYLOAD;
          end else begin
            count_next = count + 1'b1;
          end
        end
      end
      default: state_next = PAYLOAD;
    endcase
  end

endmodule

// File: tb/tb_packet_crc_framer.sv
// Testbench for packet_crc_framer. Two instances: index 0 with PKT_BITS=16
// for the directed frame cases, index 1 with default parameters for a long
// random frame. Stimulus pushes expected output transfers into a per-instance
// queue; a negedge monitor pops and compares on every output transfer and
// checks that outputs hold while stalled.
module tb_packet_crc_framer;

  typedef struct packed {
    logic b;
    logic sop;
    logic eop;
  } xfer_t;

  logic clk = 1'b0;
  logic rst       [2];
  logic bit_in    [2];
  logic valid_in  [2];
  logic ready_in  [2];
  logic ready_out [2];
  logic bit_out   [2];
  logic valid_out [2];
  logic sop       [2];
  logic eop       [2];

  int    total = 0;
  int    bad   = 0;
  xfer_t exp_q [2][$];
  int    rdy_pct  [2] = '{100, 100};
  int    ro_low   [2] = '{0, 0};
  int    cur_run  [2] = '{0, 0};
  int    last_run [2] = '{0, 0};
  int    nxfer    [2] = '{0, 0};
  logic  stall_prev [2] = '{1'b0, 1'b0};
  logic [3:0] stall_val [2];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      packet_crc_framer #(
        .PKT_BITS((gi == 0) ? 16 : 1504),
        .CRC_SIZE(8)
      ) dut (
        .clk      (clk),
        .rst      (rst[gi]),
        .bit_in   (bit_in[gi]),
        .valid_in (valid_in[gi]),
        .ready_out(ready_out[gi]),
        .bit_out  (bit_out[gi]),
        .valid_out(valid_out[gi]),
        .ready_in (ready_in[gi]),
        .sop      (sop[gi]),
        .eop      (eop[gi])
      );
    end
  endgenerate

  // Downstream ready, re-randomised each cycle just after the edge.
  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) ready_in[d] = ($urandom_range(99) < rdy_pct[d]);
  end

  // Reference CRC: reflected 8-bit LFSR, feedback mask 0xAB.
  function automatic logic [7:0] ref_crc(input logic pl[$]);
    logic [7:0] c;
    c = 8'h00;
    foreach (pl[i]) c = (c >> 1) ^ (((c[0] ^ pl[i]) == 1'b1) ? 8'hAB : 8'h00);
    return c;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) begin
        stall_prev[d] = 1'b0;
        cur_run[d]    = 0;
        continue;
      end
      if (stall_prev[d]) begin
        total++;
        if ({valid_out[d], bit_out[d], sop[d], eop[d]} != stall_val[d]) begin
          bad++;
          $display("FAIL hold_d%0d got v/b/sop/eop=%b%b%b%b want %b", d,
                   valid_out[d], bit_out[d], sop[d], eop[d], stall_val[d]);
        end
      end
      stall_prev[d] = valid_out[d] && !ready_in[d];
      stall_val[d]  = {valid_out[d], bit_out[d], sop[d], eop[d]};
      if (valid_out[d]) cur_run[d]++;
      else begin
        if (cur_run[d] != 0) last_run[d] = cur_run[d];
        cur_run[d] = 0;
      end
      if (!ready_out[d] && (!valid_out[d] || ready_in[d])) ro_low[d]++;
      if (valid_out[d] && ready_in[d]) begin
        xfer_t got, e;
        got.b = bit_out[d]; got.sop = sop[d]; got.eop = eop[d];
        total++;
        if (exp_q[d].size() == 0) begin
          bad++;
          $display("FAIL xfer_d%0d unexpected output b/sop/eop=%b want none", d, got);
        end else begin
          e = exp_q[d].pop_front();
          if (got != e) begin
            bad++;
            $display("FAIL xfer_d%0d #%0d got b/sop/eop=%b want %b", d, nxfer[d], got, e);
          end
        end
        $display("xfer d%0d #%0d bit=%b sop=%b eop=%b", d, nxfer[d], got.b, got.sop, got.eop);
        nxfer[d]++;
      end
    end
  end

  task automatic send_bit(input int d, input logic b);
    int   n;
    logic acc;
    n = 0;
    bit_in[d]   = b;
    valid_in[d] = 1'b1;
    forever begin
      @(negedge clk);
      acc = ready_out[d];
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 300) begin
        total++; bad++;
        $display("FAIL accept_d%0d timeout got ready_out=0 want 1", d);
        break;
      end
    end
  endtask

  task automatic send_frame(input int d, input logic pl[$], input logic [7:0] crc, input int gap_pct);
    xfer_t e;
    foreach (pl[i]) begin
      e.b = pl[i]; e.sop = (i == 0); e.eop = 1'b0;
      exp_q[d].push_back(e);
    end
    for (int i = 7; i >= 0; i--) begin
      e.b = crc[i]; e.sop = 1'b0; e.eop = (i == 0);
      exp_q[d].push_back(e);
    end
    foreach (pl[i]) begin
      if ($urandom_range(99) < gap_pct) begin
        valid_in[d] = 1'b0;
        bit_in[d]   = 1'($urandom);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send_bit(d, pl[i]);
    end
    valid_in[d] = 1'b0;
  endtask

  task automatic wait_drain(input int d);
    int n;
    n = 0;
    while (exp_q[d].size() != 0 && n < 8000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q[d].size() != 0) begin
      total++; bad++;
      $display("FAIL drain_d%0d left=%0d want 0", d, exp_q[d].size());
      exp_q[d].delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic pl[$];
    logic imp[$];
    int   ro0;

    imp = {};
    imp.push_back(1'b1);
    repeat (7) imp.push_back(1'b0);

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; bit_in[d] = 1'b0; valid_in[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({valid_out[d], bit_out[d], sop[d], eop[d], ready_out[d]} != 5'b00001) begin
        bad++;
        $display("FAIL reset_d%0d got v/b/sop/eop/rdy=%b%b%b%b%b want 00001", d,
                 valid_out[d], bit_out[d], sop[d], eop[d], ready_out[d]);
      end
      rst[d] = 1'b0;
    end
    @(posedge clk); #1;

    // Zero payload: all-zero frame, ready_out low for 8 slot-free cycles.
    pl = {};
    repeat (8) pl.push_back(1'b0);
    ro0 = ro_low[0];
    send_frame(0, pl, 8'h00, 0);
    wait_drain(0);
    total++;
    if (ro_low[0] - ro0 != 8) begin
      bad++;
      $display("FAIL ready_low got=%0d want 8", ro_low[0] - ro0);
    end

    // Impulse payload
    send_frame(0, imp, 8'hF7, 0);
    wait_drain(0);

    // Back-to-back frames: seed resets, no bubbles.
    send_frame(0, imp, 8'hF7, 0);
    send_frame(0, imp, 8'hF7, 0);
    wait_drain(0);
    total++;
    if (last_run[0] != 32) begin
      bad++;
      $display("FAIL b2b_run got=%0d want 32", last_run[0]);
    end

    // Mid-frame reset after 5 payload bits.
    pl = {};
    for (int i = 0; i < 5; i++) pl.push_back(1'($urandom));
    for (int i = 0; i < 5; i++) begin
      xfer_t e;
      e.b = pl[i]; e.sop = (i == 0); e.eop = 1'b0;
      exp_q[0].push_back(e);
    end
    foreach (pl[i]) send_bit(0, pl[i]);
    valid_in[0] = 1'b0;
    rst[0] = 1'b1;
    exp_q[0].delete();
    #1;
    total++;
    if (valid_out[0] !== 1'b0) begin
      bad++;
      $display("FAIL midreset_valid got=%b want 0", valid_out[0]);
    end
    @(posedge clk); #1;
    rst[0] = 1'b0;
    send_frame(0, imp, 8'hF7, 0);
    wait_drain(0);

    // Back-pressure and input gaps with random payloads.
    rdy_pct[0] = 50;
    send_frame(0, imp, 8'hF7, 30);
    for (int f = 0; f < 6; f++) begin
      pl = {};
      repeat (8) pl.push_back(1'($urandom));
      send_frame(0, pl, ref_crc(pl), 30);
    end
    wait_drain(0);
    rdy_pct[0] = 100;

    // Default parameters: one long random frame under back-pressure.
    rdy_pct[1] = 50;
    pl = {};
    repeat (1496) pl.push_back(1'($urandom));
    send_frame(1, pl, ref_crc(pl), 0);
    wait_drain(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
